// File: rtl/shader_spi_pkg.sv
// Shared types and constants for the shader SPI front-end.
// Command codes, command-FSM states and the byte width used across the block.
package shader_spi_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic [7:0] {
    CMD_NOP        = 8'h00,
    CMD_WRITE_USER = 8'h01,
    CMD_READ_USER  = 8'h02,
    CMD_SHIFT      = 8'h03
  } cmd_e;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_WR_USER,
    ST_RD_USER
  } state_e;

endpackage

// File: rtl/shader_spi_frontend_sync_ff.sv
// Single-bit multi-flop synchroniser bringing an asynchronous pin into clk_i.
// RESET_VAL lets each pin start from its idle level.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/shader_spi_frontend.sv
// SPI slave front-end: assembles MOSI bytes in the pixel clock domain and turns them
// into user-register commands (command mode) or shader-memory load/shift pulses (data mode).
module shader_spi_frontend
  import shader_spi_pkg::*;
#(
  parameter int                  REG_SIZE    = 6,
  parameter logic [REG_SIZE-1:0] REG_DEFAULT = 6'd42,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 spi_sclk_i,
  input  logic                 spi_mosi_i,
  input  logic                 spi_cs_i,
  output logic                 spi_miso_o,
  input  logic                 mode_i,
  output logic [BYTE_BITS-1:0] memory_instr_o,
  output logic                 memory_load_o,
  output logic                 memory_shift_o,
  output logic [REG_SIZE-1:0]  user_o
);

  logic sclk_s, mosi_s, cs_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sclk_i), .q_o(sclk_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_mosi_i), .q_o(mosi_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_cs_i), .q_o(cs_s)
  );

  logic                 sclk_prev_q, cs_prev_q;
  logic                 fall_q, rise_q, mosi_q;
  logic [2:0]           bit_cnt_q;
  logic [BYTE_BITS-1:0] rx_q;
  logic                 byte_valid_q;
  logic [BYTE_BITS-1:0] tx_q;
  logic                 miso_q;
  state_e               state_q;
  logic [REG_SIZE-1:0]  user_q;
  logic [BYTE_BITS-1:0] instr_q;
  logic                 load_q, shift_q;

  logic cs_rise;
  assign cs_rise = cs_s & ~cs_prev_q;

  // Edges are registered one extra stage so MOSI is captured alongside the SCLK edge
  // it belongs to; the byte then takes one more cycle to turn into an output pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      fall_q       <= 1'b0;
      rise_q       <= 1'b0;
      mosi_q       <= 1'b0;
      bit_cnt_q    <= 3'd0;
      rx_q         <= '0;
      byte_valid_q <= 1'b0;
      tx_q         <= '0;
      miso_q       <= 1'b0;
      state_q      <= ST_CMD;
      user_q       <= REG_DEFAULT;
      instr_q      <= '0;
      load_q       <= 1'b0;
      shift_q      <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      fall_q       <= sclk_prev_q & ~sclk_s & ~cs_s;
      rise_q       <= ~sclk_prev_q & sclk_s & ~cs_s;
      mosi_q       <= mosi_s;
      byte_valid_q <= 1'b0;
      load_q       <= 1'b0;
      shift_q      <= 1'b0;

      if (cs_s) begin
        bit_cnt_q <= 3'd0;
      end else if (fall_q) begin
        rx_q         <= {rx_q[BYTE_BITS-2:0], mosi_q};
        bit_cnt_q    <= bit_cnt_q + 3'd1;
        byte_valid_q <= (bit_cnt_q == 3'd7);
      end

      // MISO presents the current MSB on each rising edge, then the register moves on.
      if (cs_s) begin
        miso_q <= 1'b0;
      end else if (rise_q) begin
        miso_q <= (state_q == ST_RD_USER) & tx_q[BYTE_BITS-1];
        tx_q   <= {tx_q[BYTE_BITS-2:0], 1'b0};
      end

      if (cs_rise) begin
        state_q <= ST_CMD;
        tx_q    <= '0;
      end else if (byte_valid_q) begin
        if (mode_i) begin
          instr_q <= rx_q;
          load_q  <= 1'b1;
          shift_q <= 1'b1;
        end else begin
          case (state_q)
            ST_CMD: begin
              case (rx_q)
                CMD_NOP:        ;
                CMD_WRITE_USER: state_q <= ST_WR_USER;
                CMD_READ_USER: begin
                  tx_q    <= BYTE_BITS'(user_q);
                  state_q <= ST_RD_USER;
                end
                CMD_SHIFT:      shift_q <= 1'b1;
                default:        ;
              endcase
            end
            ST_WR_USER: begin
              user_q  <= rx_q[REG_SIZE-1:0];
              state_q <= ST_CMD;
            end
            ST_RD_USER: begin
              tx_q    <= '0;
              miso_q  <= 1'b0;
              state_q <= ST_CMD;
            end
            default: state_q <= ST_CMD;
          endcase
        end
      end
    end
  end

  assign spi_miso_o     = miso_q;
  assign memory_instr_o = instr_q;
  assign memory_load_o  = load_q;
  assign memory_shift_o = shift_q;
  assign user_o         = user_q;

endmodule

// File: tb/tb_shader_spi_frontend.sv
// Bench for shader_spi_frontend: directed scenarios plus a randomized byte stream,
// scored against a transaction-level model of the host-visible behaviour.
module tb_shader_spi_frontend;

  localparam int REG_SIZE = 6;
  localparam int SYNC     = 2;
  localparam int HALF     = 4;
  localparam int EW       = 42;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                spi_sclk = 1'b0;
  logic                spi_mosi = 1'b0;
  logic                spi_cs = 1'b1;
  logic                spi_miso;
  logic                mode = 1'b0;
  logic [7:0]          memory_instr;
  logic                memory_load;
  logic                memory_shift;
  logic [REG_SIZE-1:0] user;

  shader_spi_frontend #(
    .REG_SIZE(REG_SIZE), .REG_DEFAULT(6'd42), .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .spi_sclk_i(spi_sclk), .spi_mosi_i(spi_mosi),
    .spi_cs_i(spi_cs), .spi_miso_o(spi_miso), .mode_i(mode),
    .memory_instr_o(memory_instr), .memory_load_o(memory_load),
    .memory_shift_o(memory_shift), .user_o(user)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard: expected pulse events {cycle, load, shift, instr}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_e, exp_e;

  // Host-level reference model
  int                  m_await;   // 0 idle, 1 awaiting write argument, 2 read in progress
  logic [REG_SIZE-1:0] m_user;
  logic [7:0]          m_instr;
  logic [7:0]          m_rdval;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_await = 0;
    m_user  = 6'd42;
    m_instr = 8'h00;
    m_rdval = 8'h00;
  endtask

  // Effects of a completed byte; the pulse is due SYNC+2 edges after the edge that
  // first sees the 8th falling SCLK (that edge is fall_cyc+1).
  task automatic model_byte(input logic [7:0] b, input logic md, input int fall_cyc);
    int due;
    due = fall_cyc + 1 + SYNC + 2;
    if (md) begin
      m_instr = b;
      exp_q.push_back({32'(due), 1'b1, 1'b1, b});
    end else if (m_await == 1) begin
      m_user  = b[REG_SIZE-1:0];
      m_await = 0;
    end else if (m_await == 2) begin
      m_await = 0;
    end else begin
      case (b)
        8'h01: m_await = 1;
        8'h02: begin m_await = 2; m_rdval = 8'(m_user); end
        8'h03: exp_q.push_back({32'(due), 1'b0, 1'b1, m_instr});
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (memory_load || memory_shift)) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_pulse: observed load=%0b shift=%0b at cycle %0d expected none",
               memory_load, memory_shift, cyc);
      end
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        obs_e = {32'(cyc), memory_load, memory_shift, memory_instr};
        n_checks++;
        assert (obs_e === exp_e) else begin
          n_err++;
          $error("FAIL pulse_event: observed cyc=%0d ld=%0b sh=%0b instr=%0h expected cyc=%0d ld=%0b sh=%0b instr=%0h",
                 obs_e[41:10], obs_e[9], obs_e[8], obs_e[7:0],
                 exp_e[41:10], exp_e[9], exp_e[8], exp_e[7:0]);
        end
      end
    end
  end

  // Driver tasks (called at a negedge)
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [7:0] b, input int nbits, input logic md,
                          output logic [7:0] miso_cap);
    miso_cap = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b1;
      spi_mosi = b[7-i];
      wait_cyc(HALF);
      miso_cap = {miso_cap[6:0], spi_miso};
      spi_sclk = 1'b0;
      if (i == 7) model_byte(b, md, cyc);
      wait_cyc(HALF);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic md);
    logic [7:0] cap;
    logic [7:0] exp_m;
    mode  = md;
    exp_m = (m_await == 2) ? m_rdval : 8'h00;
    spi_xfer(b, 8, md, cap);
    check("miso_byte", 32'(cap), 32'(exp_m));
  endtask

  task automatic cs_cycle();
    spi_cs = 1'b1;
    wait_cyc(6);
    m_await = 0;
    spi_cs = 1'b0;
    wait_cyc(6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    model_reset();
    wait_cyc(1);
  endtask

  logic [7:0] junk;

  initial begin
    model_reset();
    // Reset state
    do_reset();
    check("rst_user", 32'(user), 32'd42);
    check("rst_load", 32'(memory_load), 32'd0);
    check("rst_shift", 32'(memory_shift), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_instr", 32'(memory_instr), 32'd0);

    // Data byte
    spi_cs = 1'b0;
    wait_cyc(6);
    send_byte(8'hA5, 1'b1);
    wait_cyc(6);
    check("data_instr", 32'(memory_instr), 32'hA5);

    // Write user then shift command (back-to-back bytes)
    send_byte(8'h01, 1'b0);
    send_byte(8'h15, 1'b0);
    wait_cyc(6);
    check("wr_user", 32'(user), 32'h15);
    send_byte(8'h03, 1'b0);
    wait_cyc(6);
    check("shift_keeps_instr", 32'(memory_instr), 32'hA5);

    // Read user after reset
    spi_cs = 1'b1;
    do_reset();
    spi_cs = 1'b0;
    wait_cyc(6);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_cyc(6);
    check("miso_after_read", 32'(spi_miso), 32'd0);

    // Abort a partial byte, then a clean data byte
    mode = 1'b1;
    spi_xfer(8'hFF, 5, 1'b1, junk);
    cs_cycle();
    send_byte(8'h3C, 1'b1);
    wait_cyc(6);
    check("abort_instr", 32'(memory_instr), 32'h3C);

    // Reset in the middle of a write argument
    send_byte(8'h01, 1'b0);
    spi_xfer(8'hFF, 3, 1'b0, junk);
    do_reset();
    check("midrst_user", 32'(user), 32'd42);
    check("midrst_instr", 32'(memory_instr), 32'd0);
    cs_cycle();
    send_byte(8'h01, 1'b0);
    send_byte(8'h07, 1'b0);
    wait_cyc(6);
    check("midrst_wr_user", 32'(user), 32'h07);

    // Randomized stream against the model
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic       md;
      if ($urandom_range(0, 5) == 0) cs_cycle();
      md = (m_await == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      b  = ($urandom_range(0, 3) < 3) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      send_byte(b, md);
      wait_cyc(6);
      check("rand_user", 32'(user), 32'(m_user));
      check("rand_instr", 32'(memory_instr), 32'(m_instr));
    end

    spi_cs = 1'b1;
    wait_cyc(10);
    check("pending_events", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
